// File: rtl/fdtd_field_update.sv
// Streaming FDTD leapfrog update F_new = c_self*F_old + c_curl*(A[i]-A[i-1]).
// Four-stage fixed-latency pipeline with global clock enable, single final rounding and saturation.
module fdtd_field_update #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 21,
    parameter int ROUND      = 1,
    parameter int SATURATE   = 1,
    parameter int DIFF_DIR   = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clken,
    input  logic                  in_valid,
    input  logic                  in_sol,
    input  logic [DATA_WIDTH-1:0] field_old_i,
    input  logic [DATA_WIDTH-1:0] curl_i,
    input  logic [DATA_WIDTH-1:0] coef_self,
    input  logic [DATA_WIDTH-1:0] coef_curl,
    input  logic                  sat_clr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] field_new_o,
    output logic                  sat_flag
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW + 2;
    localparam logic signed [PW-1:0] RND_C = (ROUND != 0) ? (PW'(1) << (FRAC_BITS - 1)) : '0;
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0]          a_prev_q;
    logic                   v1_q;
    logic [DW-1:0]          left_q, curl1_q, old1_q, cs1_q, cc1_q;
    logic                   v2_q;
    logic signed [DW:0]     diff2_q;
    logic [DW-1:0]          old2_q, cs2_q, cc2_q;
    logic                   v3_q;
    logic signed [2*DW:0]   pcurl3_q;
    logic signed [2*DW-1:0] pself3_q;
    logic                   out_valid_q;
    logic [DW-1:0]          field_q;
    logic                   sat_q;

    logic [DW-1:0]          left_d;
    logic signed [DW:0]     diff_d;
    logic signed [2*DW:0]   pcurl_d;
    logic signed [2*DW-1:0] pself_d;
    logic signed [PW-1:0]   sum_d;
    logic signed [PW-1:0]   shifted;
    logic                   ovf;
    logic                   clamp_d;
    logic [DW-1:0]          res_d;
    logic                   sat_d;

    // Start of line models the PEC boundary: the missing neighbour reads as zero.
    assign left_d = in_sol ? '0 : a_prev_q;

    always_comb begin
        diff_d = '0;
        if (DIFF_DIR != 0) begin
            diff_d = $signed({left_q[DW-1], left_q}) - $signed({curl1_q[DW-1], curl1_q});
        end else begin
            diff_d = $signed({curl1_q[DW-1], curl1_q}) - $signed({left_q[DW-1], left_q});
        end
    end

    assign pcurl_d = $signed({{DW{diff2_q[DW]}}, diff2_q})
                   * $signed({{(DW+1){cc2_q[DW-1]}}, cc2_q});
    assign pself_d = $signed({{DW{old2_q[DW-1]}}, old2_q})
                   * $signed({{DW{cs2_q[DW-1]}}, cs2_q});

    // Products stay full precision so the one rounding step happens only here.
    always_comb begin
        sum_d   = $signed({pcurl3_q[2*DW], pcurl3_q})
                + $signed({{2{pself3_q[2*DW-1]}}, pself3_q}) + RND_C;
        shifted = sum_d >>> FRAC_BITS;
        ovf     = !((&shifted[PW-1:DW-1]) || !(|shifted[PW-1:DW-1]));
        clamp_d = (SATURATE != 0) && ovf;
        res_d   = shifted[DW-1:0];
        if (clamp_d) begin
            res_d = shifted[PW-1] ? MINV : MAXV;
        end
    end

    // A new saturation event outranks a simultaneous clear.
    always_comb begin
        sat_d = sat_q;
        if (clken && v3_q && clamp_d) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_prev_q    <= '0;
            v1_q        <= 1'b0;
            left_q      <= '0;
            curl1_q     <= '0;
            old1_q      <= '0;
            cs1_q       <= '0;
            cc1_q       <= '0;
            v2_q        <= 1'b0;
            diff2_q     <= '0;
            old2_q      <= '0;
            cs2_q       <= '0;
            cc2_q       <= '0;
            v3_q        <= 1'b0;
            pcurl3_q    <= '0;
            pself3_q    <= '0;
            out_valid_q <= 1'b0;
            field_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            sat_q <= sat_d;
            if (clken) begin
                if (in_valid) begin
                    a_prev_q <= curl_i;
                end
                v1_q        <= in_valid;
                left_q      <= left_d;
                curl1_q     <= curl_i;
                old1_q      <= field_old_i;
                cs1_q       <= coef_self;
                cc1_q       <= coef_curl;
                v2_q        <= v1_q;
                diff2_q     <= diff_d;
                old2_q      <= old1_q;
                cs2_q       <= cs1_q;
                cc2_q       <= cc1_q;
                v3_q        <= v2_q;
                pcurl3_q    <= pcurl_d;
                pself3_q    <= pself_d;
                out_valid_q <= v3_q;
                if (v3_q) begin
                    field_q <= res_d;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign field_new_o = field_q;
    assign sat_flag    = sat_q;

endmodule
